// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cipher_pkg
// Brief   : Shared types and constants for the keystream / XOR / mux path.
// Revision: 1.0
// ============================================================================
package cipher_pkg;

    localparam int          KS_LFSR_W       = 32;
    localparam int          KS_N            = 8;
    localparam logic [31:0] KS_TAPS         = 32'h8020_0003;
    localparam logic [31:0] KS_DEFAULT_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } ks_state_t;

endpackage
`default_nettype wire

// File: rtl/keystream_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : keystream_gen_if
// Brief   : Key-load pins and keystream valid/ready handshake bundle.
// Revision: 1.0
// ============================================================================
interface keystream_gen_if
    import cipher_pkg::*;
#(
    parameter int N = KS_N
) ();

    logic         key_in;
    logic         key_load;
    logic         ks_ready;
    logic [N-1:0] ks_byte;
    logic         ks_valid;
    logic         key_err;
    logic         running;

    modport master (
        input  key_in,
        input  key_load,
        input  ks_ready,
        output ks_byte,
        output ks_valid,
        output key_err,
        output running
    );

    modport slave (
        output key_in,
        output key_load,
        output ks_ready,
        input  ks_byte,
        input  ks_valid,
        input  key_err,
        input  running
    );

endinterface
`default_nettype wire

// File: rtl/lfsr_galois.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_galois
// Brief   : Right-shifting Galois LFSR; load wins over step, output is state[0].
// Revision: 1.0
// ============================================================================
module lfsr_galois
    import cipher_pkg::*;
#(
    parameter int           W    = KS_LFSR_W,
    parameter logic [W-1:0] TAPS = W'(KS_TAPS)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         load,
    input  wire logic [W-1:0] seed,
    input  wire logic         step,
    output logic      [W-1:0] state,
    output logic              bit_out
);

    logic [W-1:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
        end
    end

    assign state   = r_state;
    assign bit_out = r_state[0];

endmodule
`default_nettype wire

// File: rtl/keystream_gen.sv
`default_nettype none
// ============================================================================
// Module  : keystream_gen
// Brief   : Serial key load, LFSR seeding and MSB-first keystream words on a
//           valid/ready handshake with one word of buffering in the accumulator.
// Revision: 1.0
// ============================================================================
module keystream_gen
    import cipher_pkg::*;
#(
    parameter int                LFSR_W       = KS_LFSR_W,
    parameter int                N            = KS_N,
    parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(KS_TAPS),
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(KS_DEFAULT_SEED)
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    keystream_gen_if.master ks
);

    localparam int              CW          = $clog2(LFSR_W + 2);
    localparam int              ACW         = $clog2(N + 1);
    localparam logic [CW-1:0]   c_cnt_full  = CW'(LFSR_W);
    localparam logic [CW-1:0]   c_cnt_sat   = CW'(LFSR_W + 1);
    localparam logic [CW-1:0]   c_cnt_one   = CW'(1);
    localparam logic [ACW-1:0]  c_acc_full  = ACW'(N);
    localparam logic [ACW-1:0]  c_acc_last  = ACW'(N - 1);
    localparam logic [ACW-1:0]  c_acc_one   = ACW'(1);

    ks_state_t          r_state,   w_state_nxt;
    logic [CW-1:0]      r_cnt,     w_cnt_nxt;
    logic [LFSR_W-1:0]  r_key_sr,  w_key_sr_nxt;
    logic [N-1:0]       r_acc,     w_acc_nxt;
    logic [ACW-1:0]     r_acc_cnt, w_acc_cnt_nxt;
    logic [N-1:0]       r_ks_byte, w_byte_nxt;
    logic               r_ks_valid, w_valid_nxt;
    logic               r_key_err,  w_key_err_nxt;

    logic               w_free;
    logic               w_step;
    logic               w_commit_ok;
    logic               w_bit;
    logic [N-1:0]       w_word;
    logic [LFSR_W-1:0]  w_seed;
    logic [LFSR_W-1:0]  w_lfsr_state;
    logic               w_unused_lfsr;

    assign w_free      = !r_ks_valid || ks.ks_ready;
    assign w_step      = (r_state == RUN) && !ks.key_load &&
                         ((r_acc_cnt != c_acc_full) || w_free);
    assign w_commit_ok = (r_state == LOAD) && !ks.key_load && (r_cnt == c_cnt_full);
    assign w_seed      = (r_key_sr == '0) ? DEFAULT_SEED : r_key_sr;
    assign w_word      = {r_acc[N-2:0], w_bit};

    lfsr_galois #(
        .W    (LFSR_W),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_commit_ok),
        .seed    (w_seed),
        .step    (w_step),
        .state   (w_lfsr_state),
        .bit_out (w_bit)
    );

    // Full state is only needed for debug visibility inside the LFSR.
    assign w_unused_lfsr = ^w_lfsr_state;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_key_sr_nxt  = r_key_sr;
        w_acc_nxt     = r_acc;
        w_acc_cnt_nxt = r_acc_cnt;
        w_byte_nxt    = r_ks_byte;
        w_valid_nxt   = r_ks_valid;
        w_key_err_nxt = 1'b0;

        if (ks.key_load) begin
            w_state_nxt   = LOAD;
            w_key_sr_nxt  = {r_key_sr[LFSR_W-2:0], ks.key_in};
            if (r_cnt != c_cnt_sat) begin
                w_cnt_nxt = r_cnt + c_cnt_one;
            end
            w_acc_nxt     = '0;
            w_acc_cnt_nxt = '0;
            w_valid_nxt   = 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    w_cnt_nxt     = '0;
                    w_acc_nxt     = '0;
                    w_acc_cnt_nxt = '0;
                    if (r_cnt == c_cnt_full) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_key_err_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (r_ks_valid && ks.ks_ready) begin
                        w_valid_nxt = 1'b0;
                    end
                    if (w_step) begin
                        if (r_acc_cnt == c_acc_full) begin
                            // Buffered word moves out; this step's bit starts the next word.
                            w_byte_nxt    = r_acc;
                            w_valid_nxt   = 1'b1;
                            w_acc_nxt     = {{(N-1){1'b0}}, w_bit};
                            w_acc_cnt_nxt = c_acc_one;
                        end else if (r_acc_cnt == c_acc_last) begin
                            if (w_free) begin
                                w_byte_nxt    = w_word;
                                w_valid_nxt   = 1'b1;
                                w_acc_nxt     = '0;
                                w_acc_cnt_nxt = '0;
                            end else begin
                                w_acc_nxt     = w_word;
                                w_acc_cnt_nxt = c_acc_full;
                            end
                        end else begin
                            w_acc_nxt     = w_word;
                            w_acc_cnt_nxt = r_acc_cnt + c_acc_one;
                        end
                    end
                end
                default: begin
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_key_sr   <= '0;
            r_acc      <= '0;
            r_acc_cnt  <= '0;
            r_ks_byte  <= '0;
            r_ks_valid <= 1'b0;
            r_key_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_key_sr   <= w_key_sr_nxt;
            r_acc      <= w_acc_nxt;
            r_acc_cnt  <= w_acc_cnt_nxt;
            r_ks_byte  <= w_byte_nxt;
            r_ks_valid <= w_valid_nxt;
            r_key_err  <= w_key_err_nxt;
        end
    end

    assign ks.ks_byte  = r_ks_byte;
    assign ks.ks_valid = r_ks_valid;
    assign ks.key_err  = r_key_err;
    assign ks.running  = (r_state == RUN);

endmodule
`default_nettype wire

// File: doc/keystream_gen.md
# keystream_gen

Serial-keyed keystream generator feeding the cipher datapath. It takes a key serially from the pins, seeds a 32-bit Galois LFSR, and emits MSB-first keystream bytes on a valid/ready handshake. The downstream stage XORs each byte with plaintext, and the output select mux picks cipher or bypass data. The block owns all sequential keystream state, so the downstream path stays purely combinational.

## Interface
- `LFSR_W`, default 32: LFSR and key width.
- `N`, default 8: keystream word width; matches the mux data width.
- `TAPS`, default 32'h8020_0003: Galois feedback mask for x^32+x^22+x^2+x+1.
- `DEFAULT_SEED`, default 32'h0000_0001: seed substituted when the loaded key is all-zero.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `key_in`, input, 1: serial key bit, sampled while `key_load`=1.
- `key_load`, input, 1: load window; high for exactly `LFSR_W` cycles to load a key.
- `ks_ready`, input, 1: downstream accepts `ks_byte` this cycle.
- `ks_byte`, output, N: keystream word, registered.
- `ks_valid`, output, 1: `ks_byte` holds an unconsumed word.
- `key_err`, output, 1: one-cycle pulse when a load window had the wrong length.
- `running`, output, 1: high in state RUN.

## Operation
- States: IDLE, LOAD, RUN. Reset state is IDLE.
- Reset values: `ks_byte`=0, `ks_valid`=0, `key_err`=0, `running`=0. LFSR, shift register, bit counter and accumulator all reset to 0.
- **Any state, `key_load`=1:**
  - Next state is LOAD.
  - Shift register: `key_sr <= {key_sr[W-2:0], key_in}` (MSB first).
  - Bit counter increments and saturates at `LFSR_W`+1.
  - On entry to LOAD from RUN: `ks_valid` is cleared, the accumulator is cleared, and the pending word is discarded.
- **LOAD, `key_load`=0 (commit edge):**
  - If count == `LFSR_W`: LFSR <= (`key_sr`==0 ? `DEFAULT_SEED` : `key_sr`), accumulator cleared, go to RUN.
  - Otherwise: pulse `key_err`, go to IDLE; the previous key is lost.
  - In both cases the counter clears.
- **IDLE:** LFSR frozen, `ks_valid`=0.
- **RUN, step condition:** a step occurs when the accumulator is not full, or when it is full and the output register is free (`!ks_valid || ks_ready`).
- **RUN, step action:**
  - Output bit is `lfsr[0]`, taken before the update.
  - `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0)`.
  - `acc <= {acc[N-2:0], bit}`; the first bit of a word lands in `ks_byte[N-1]`.
- **Word transfer:** when the N-th bit is shifted in and the output register is free, `ks_byte` <= completed word and `ks_valid` <= 1 on that same edge.
  - If the output register is not free, the accumulator holds the full word and the LFSR stalls until `ks_ready`.
- **Handshake:**
  - Transfer happens on any edge with `ks_valid && ks_ready`.
  - `ks_byte` must stay stable while `ks_valid && !ks_ready`.
  - If a new word completes on the same edge as an accept, the new word loads and `ks_valid` stays 1.
- **Simultaneous events:** `key_load`=1 overrides stepping and handshake. A word accepted on the LOAD-entry edge counts as consumed.
- **Reset mid-operation:** immediate return to reset values; a key must be reloaded.

## Timing
- Commit edge E0 sets `running`=1.
- Steps occur on edges E1..EN. `ks_valid` rises after EN, so first-word latency is N cycles from `running`.
- With `ks_ready` held at 1, sustained throughput is one word every N cycles and `ks_valid` stays high. Double buffering allows zero stall cycles.
- With `ks_ready`=0:
  - The next word completes N edges later.
  - The LFSR then freezes.
  - After `ks_ready` rises, the next word appears on the following edge.
- `key_err` is high exactly one cycle, the cycle after the commit edge.
- The LFSR period is 2^32−1 steps; wrap-around needs no special handling.

## Structure
- Shared package `cipher_pkg`:
  - State enum `ks_state_t` (IDLE/LOAD/RUN).
  - `KS_TAPS` and `KS_DEFAULT_SEED` constants.
  - Width constants shared with the mux and XOR stage.
- Sub-module `lfsr_galois`:
  - Parameters `W` and `TAPS`.
  - Ports: `clk`, `rst_n`, `load`, `seed`, `step`, `state`, `bit_out`.
- FSM, bit counter, accumulator and output register live in `keystream_gen`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN with `ks_valid`=1 → all outputs 0 asynchronously. After release, state IDLE and no `ks_valid` until a key is loaded.
- **Known-answer load:** load key 32'h0000_0001 (32 cycles), hold `ks_ready`=1 → `running` after commit, `ks_valid` 8 cycles later, first `ks_byte`=8'hDB.
- **Zero key:** load 32'h0000_0000 → identical stream to the known-answer case (first byte 8'hDB), since `DEFAULT_SEED` is substituted.
- **Bad length:** 31-bit and 33-bit load windows → `key_err` one-cycle pulse, state IDLE, `ks_valid` stays 0.
- **Backpressure:** hold `ks_ready`=0 for 40 cycles after the first valid → `ks_byte` stable at 8'hDB, LFSR frozen after the second word completes. Release → bytes match the reference model with no loss or duplication.
- **Rekey during RUN:** assert `key_load` while `ks_valid`=1 → `ks_valid` drops next edge. The new key's first byte matches the model.
